// File: rtl/pred_gshare_pkg.sv
// rtl/pred_gshare_pkg.sv - gshare predictor constants, in-flight entry type and counter helper
package pred_gshare_pkg;
    localparam int ADDR     = 64;
    localparam int CNTW     = 2;
    localparam int PRT_D    = 1024;
    localparam int IDXW     = $clog2(PRT_D);
    localparam int HISTW    = 10;
    localparam int PRED_D   = 8;
    localparam int PW       = $clog2(PRED_D);
    localparam int QCW      = PW + 1;
    localparam int SIMBRF   = 2;
    localparam int SIMBRCOM = 2;

    localparam logic [CNTW-1:0] CNT_INIT = CNTW'((1 << (CNTW - 1)) - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic [IDXW-1:0]  idx;
        logic             pred;
        logic [HISTW-1:0] hist;
    } pred_info_t;

    function automatic logic [CNTW-1:0] sat_upd(input logic [CNTW-1:0] c, input logic up);
        logic [CNTW-1:0] r;
        if (up) r = (c == CNT_MAX) ? c : c + CNTW'(1);
        else    r = (c == '0)      ? c : c - CNTW'(1);
        return r;
    endfunction
endpackage

// File: rtl/pred_gshare_if.sv
// rtl/pred_gshare_if.sv - fetch, commit and observation bundle of the gshare predictor
interface pred_gshare_if;
    import pred_gshare_pkg::*;

    logic                        flush_;
    logic [SIMBRF-1:0]           br_;
    logic [SIMBRF-1:0][ADDR-1:0] br_addr;
    logic [SIMBRF-1:0]           pred_taken;
    logic [SIMBRCOM-1:0]         br_commit_;
    logic [SIMBRCOM-1:0]         br_taken_;
    logic [SIMBRCOM-1:0]         br_pred_miss_;
    logic                        busy;
    logic [HISTW-1:0]            dbg_ghr_spec;
    logic [HISTW-1:0]            dbg_ghr_arch;
    logic [QCW-1:0]              dbg_count;
    logic [IDXW-1:0]             dbg_idx;
    logic [CNTW-1:0]             dbg_cnt;

    modport master (
        output flush_, br_, br_addr, br_commit_, br_taken_, br_pred_miss_, dbg_idx,
        input  pred_taken, busy, dbg_ghr_spec, dbg_ghr_arch, dbg_count, dbg_cnt
    );

    modport slave (
        input  flush_, br_, br_addr, br_commit_, br_taken_, br_pred_miss_, dbg_idx,
        output pred_taken, busy, dbg_ghr_spec, dbg_ghr_arch, dbg_count, dbg_cnt
    );
endinterface

// File: rtl/pred_gshare_queue.sv
// rtl/pred_gshare_queue.sv - multi-push/multi-pop circular FIFO of in-flight prediction info
module pred_gshare_queue
    import pred_gshare_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [SIMBRF-1:0] push_vld,
    input  pred_info_t        push_data [SIMBRF],
    input  logic [QCW-1:0]    pop_n,
    output pred_info_t        head [SIMBRCOM],
    output logic [QCW-1:0]    count,
    output logic              busy
);
    pred_info_t     mem_q [PRED_D];
    pred_info_t     mem_d [PRED_D];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [QCW-1:0] count_q, count_d;

    // Valid pushes are packed contiguously from the write pointer in slot order.
    always_comb begin
        logic [PW-1:0]  wp;
        logic [QCW-1:0] pn;
        mem_d = mem_q;
        wp    = wr_ptr_q;
        pn    = '0;
        for (int i = 0; i < SIMBRF; i++) begin
            if (push_vld[i]) begin
                mem_d[wp] = push_data[i];
                wp        = wp + PW'(1);
                pn        = pn + QCW'(1);
            end
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wp;
            rd_ptr_d = rd_ptr_q + pop_n[PW-1:0];
            count_d  = count_q + pn - pop_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PRED_D; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < SIMBRCOM; k++) head[k] = mem_q[rd_ptr_q + PW'(k)];
    end

    assign count = count_q;
    assign busy  = (QCW'(PRED_D) - count_q) < QCW'(SIMBRF);
endmodule

// File: rtl/pred_gshare.sv
// rtl/pred_gshare.sv - gshare predictor: PC xor speculative history indexes saturating counters
module pred_gshare
    import pred_gshare_pkg::*;
(
    input  logic clk,
    input  logic reset_,
    pred_gshare_if.slave bus
);
    logic [CNTW-1:0]  cnt_q [PRT_D];
    logic [HISTW-1:0] ghr_spec_q, ghr_spec_d;
    logic [HISTW-1:0] ghr_arch_q, ghr_arch_d;

    pred_info_t        push_data [SIMBRF];
    pred_info_t        head [SIMBRCOM];
    logic [SIMBRF-1:0] push_vld;
    logic [SIMBRF-1:0] pred_raw;
    logic [HISTW-1:0]  hist_after;
    logic [QCW-1:0]    pop_n;
    logic [QCW-1:0]    q_count;
    logic              q_busy;
    logic              q_clr;
    logic              accept;
    logic              miss_hit;
    logic [HISTW-1:0]  miss_ghr;

    logic [SIMBRCOM-1:0] wr_en;
    logic [IDXW-1:0]     wr_idx [SIMBRCOM];
    logic [CNTW-1:0]     wr_val [SIMBRCOM];

    // Each enabled slot sees the history already extended by lower slots' predictions.
    always_comb begin
        logic [HISTW-1:0] h;
        logic [IDXW-1:0]  idx;
        h        = ghr_spec_q;
        idx      = '0;
        pred_raw = '0;
        for (int i = 0; i < SIMBRF; i++) begin
            push_data[i] = '0;
            if (!bus.br_[i]) begin
                idx          = bus.br_addr[i][IDXW+1:2] ^ IDXW'(h);
                pred_raw[i]  = cnt_q[idx][CNTW-1];
                push_data[i] = '{idx: idx, pred: pred_raw[i], hist: h};
                h            = HISTW'({h, pred_raw[i]});
            end
        end
        hist_after = h;
    end

    // Commits retire in order; a later commit to the same index sees the earlier result.
    always_comb begin
        logic [QCW-1:0]   n;
        logic             stop;
        logic             tk;
        logic [CNTW-1:0]  cur;
        logic [HISTW-1:0] ga;
        pred_info_t       e;
        n        = '0;
        stop     = 1'b0;
        tk       = 1'b0;
        cur      = '0;
        ga       = ghr_arch_q;
        e        = '0;
        miss_hit = 1'b0;
        miss_ghr = '0;
        for (int k = 0; k < SIMBRCOM; k++) begin
            wr_en[k]  = 1'b0;
            wr_idx[k] = '0;
            wr_val[k] = '0;
        end
        for (int k = 0; k < SIMBRCOM; k++) begin
            if (!stop && !bus.br_commit_[k] && (n < q_count)) begin
                e = '0;
                for (int j = 0; j < SIMBRCOM; j++) begin
                    if (QCW'(j) == n) e = head[j];
                end
                tk  = ~bus.br_taken_[k];
                cur = cnt_q[e.idx];
                for (int j = 0; j < k; j++) begin
                    if (wr_en[j] && (wr_idx[j] == e.idx)) cur = wr_val[j];
                end
                wr_en[k]  = 1'b1;
                wr_idx[k] = e.idx;
                wr_val[k] = sat_upd(cur, tk);
                ga        = HISTW'({ga, tk});
                n         = n + QCW'(1);
                if (!bus.br_pred_miss_[k]) begin
                    miss_hit = 1'b1;
                    miss_ghr = HISTW'({e.hist, tk});
                    stop     = 1'b1;
                end
            end
        end
        ghr_arch_d = ga;
        pop_n      = n;
    end

    // Mispredict repair outranks flush, which outranks normal speculative advance.
    always_comb begin
        accept   = !q_busy && bus.flush_ && !miss_hit;
        q_clr    = miss_hit || !bus.flush_;
        push_vld = accept ? ~bus.br_ : '0;
        if (miss_hit)         ghr_spec_d = miss_ghr;
        else if (!bus.flush_) ghr_spec_d = ghr_arch_d;
        else if (accept)      ghr_spec_d = hist_after;
        else                  ghr_spec_d = ghr_spec_q;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ghr_spec_q <= '0;
            ghr_arch_q <= '0;
        end else begin
            ghr_spec_q <= ghr_spec_d;
            ghr_arch_q <= ghr_arch_d;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < PRT_D; i++) cnt_q[i] <= CNT_INIT;
        end else begin
            for (int k = 0; k < SIMBRCOM; k++) begin
                if (wr_en[k]) cnt_q[wr_idx[k]] <= wr_val[k];
            end
        end
    end

    pred_gshare_queue u_queue (
        .clk       (clk),
        .rst_n     (reset_),
        .clr       (q_clr),
        .push_vld  (push_vld),
        .push_data (push_data),
        .pop_n     (pop_n),
        .head      (head),
        .count     (q_count),
        .busy      (q_busy)
    );

    assign bus.pred_taken   = q_busy ? '0 : pred_raw;
    assign bus.busy         = q_busy;
    assign bus.dbg_ghr_spec = ghr_spec_q;
    assign bus.dbg_ghr_arch = ghr_arch_q;
    assign bus.dbg_count    = q_count;
    assign bus.dbg_cnt      = cnt_q[bus.dbg_idx];

    logic unused_bits;
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < SIMBRF; i++)
            unused_bits = unused_bits ^ (^{bus.br_addr[i][ADDR-1:IDXW+2], bus.br_addr[i][1:0]});
        for (int k = 0; k < SIMBRCOM; k++)
            unused_bits = unused_bits ^ head[k].pred;
    end
endmodule

// File: doc/pred_gshare.md
Name: pred_gshare

Overview:
Successor to the bimodal pred_cnt. A gshare conditional-branch predictor: a PRT_D-entry table of CNTW-bit saturating counters indexed by PC XOR global history. Sits in fetch, predicts up to SIMBRF branches per cycle and trains on up to SIMBRCOM in-order commits per cycle. Adds speculative global history, an in-flight info queue, and history repair on mispredict and flush.

Parameters:
ADDR, `AddrWidth (64), address width
CNTW, `PredCntWidth (2), counter width
PRT_D, `PredTableDepth (1024), table entries, power of 2; IDXW = log2(PRT_D)
HISTW, `PredHistWidth (10), global history bits, must be <= IDXW
PRED_D, `PredMaxDepth (8), in-flight queue depth, must be >= SIMBRF
SIMBRF, `SimBrFetch (2), fetch slots
SIMBRCOM, `SimBrCommit (2), commit slots

Ports:
clk  in  1  clock
reset_  in  1  asynchronous reset, active-low
flush_  in  1  pipeline flush, active-low
br_  in  SIMBRF  per-slot branch fetch valid, active-low
br_addr  in  SIMBRF*ADDR  per-slot branch PC
pred_taken  out  SIMBRF  per-slot prediction, combinational
br_commit_  in  SIMBRCOM  per-slot commit valid, active-low, in program order
br_taken_  in  SIMBRCOM  actual outcome, active-low (0 = taken)
br_pred_miss_  in  SIMBRCOM  mispredict flag, active-low
busy  out  1  queue free entries < SIMBRF, registered-count based

Behaviour:
- Reset (async): all counters = 2^(CNTW-1)-1 (weakly not-taken), ghr_spec = ghr_arch = 0, queue empty, busy = 0, pred_taken = 0.
- Index for a slot = br_addr[IDXW+1:2] XOR zero-extended history. Enabled slots are processed in ascending order. Slot i uses ghr_spec after shifting in the predictions of lower enabled slots in the same cycle.
- pred_taken[i] = counter MSB; 0-latency. It is 0 for disabled slots and for all slots while busy.
- Accepted fetch, when busy = 0, flush_ high and no mispredict commit this cycle:
  - Push {idx, pred, history snapshot before this branch} per enabled slot.
  - ghr_spec <= history shifted left by the enabled count, with predictions inserted LSB-last.
- Fetch while busy: ignored. No push, no history change.
- Commit slot k pops the queue head in order.
  - Counter[idx] saturating increment if taken, else decrement. Saturates at 2^CNTW-1 and at 0.
  - ghr_arch <= {ghr_arch, taken}.
  - Multiple commits to one index in one cycle are applied sequentially (e.g. 1 +1 +1 = 3).
  - Commit with queue empty: ignored.
- Mispredict on slot k:
  - Update counter as above.
  - ghr_spec <= {snapshot_k, actual taken}.
  - Queue cleared.
  - Commit slots > k and same-cycle fetch pushes are discarded.
- flush_ low: ghr_spec <= ghr_arch after this cycle's commits. Queue cleared. Same-cycle fetch ignored. Commits still train. Mispredict restore has priority over flush for ghr_spec.
- Same-cycle fetch and commit: prediction reads pre-update counters. Push and pop coexist.
- Queue pointers wrap modulo PRED_D. count width = log2(PRED_D)+1.
- Reset mid-operation clears everything immediately.

Decomposition:
- Constants go in cpu_config.h: PredCntWidth, PredTableDepth, PredHistWidth, PredMaxDepth.
- A shared package holds:
  - typedef pred_info_t {idx[IDXW], pred, hist[HISTW]};
  - the counter-init constant;
  - a saturating inc/dec function.
- Sub-module pred_gshare_queue: multi-push/multi-pop circular FIFO of pred_info_t with clear, count and busy.

Test Plan:
1. After reset, br_=2'b00, addrs 0xdeadbeef/0xdeadbfef -> pred_taken=2'b00, busy=0, ghr_spec=0, count=2.
2. Reset; fetch 0x100 (idx 0x40); commit taken with miss -> cnt[0x40]=2, ghr_spec=1, queue empty. Then fetch 0x104 (idx 0x41^1=0x40) -> pred_taken[0]=1.
3. PRED_D=8: four cycles of 2-slot fetch -> busy=0 after cycles 1-3, busy=1 after cycle 4. Fifth fetch ignored; count stays 8 and pred_taken=0.
4. Same index: four taken commits (2 per cycle) -> counter 1→3→3. Then four not-taken -> 0. No wrap.
5. Four in flight; commit slot0 miss, slot1 valid -> slot1 ignored, count=0, busy=0, ghr_spec={snapshot0,taken}. Concurrent fetch not pushed.
6. Five in flight, pulse reset_ low mid-cycle -> count=0, counters=1, ghr=0, pred_taken=0 asynchronously. Flush test: flush_ low -> ghr_spec equals ghr_arch next cycle.
